// File: rtl/multiword_add_sequencer.sv
// Multi-precision adder/subtractor: one shared W-bit carry-lookahead slice,
// time-shared over K chunks (LS chunk first) with a registered inter-chunk carry.
module multiword_add_sequencer #(
  parameter int unsigned W     = 16,
  parameter int unsigned K     = 4,
  parameter int unsigned IDX_W = $clog2(K)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_valid,
  output logic           start_ready,
  input  logic [W*K-1:0] op_a,
  input  logic [W*K-1:0] op_b,
  input  logic           sub,
  output logic [W*K-1:0] result,
  output logic           carry_out,
  output logic           overflow,
  output logic           done_valid,
  input  logic           done_ready
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int unsigned GRP = 4;
  localparam int unsigned NG  = (W + GRP - 1) / GRP;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(K - 1);

  logic [1:0]       state;
  logic [W*K-1:0]   a_q;
  logic [W*K-1:0]   b_q;
  logic [W*K-1:0]   result_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx;
  logic             carry_out_q;
  logic             overflow_q;

  logic [W-1:0]  slice_a;
  logic [W-1:0]  slice_b;
  logic [W-1:0]  slice_sum;
  logic [W-1:0]  gen;
  logic [W-1:0]  prop;
  logic [W:0]    c;
  logic [NG-1:0] grp_g;
  logic [NG-1:0] grp_p;
  logic [NG:0]   grp_c;

  assign slice_a = a_q[idx*W +: W];
  assign slice_b = b_q[idx*W +: W];

  // Two-level lookahead: 4-bit group generate/propagate resolve the group
  // carries, then each bit carry is derived from its own group's carry-in.
  always_comb begin
    gen   = slice_a & slice_b;
    prop  = slice_a ^ slice_b;
    grp_g = '0;
    grp_p = '1;
    for (int unsigned j = 0; j < NG; j++) begin
      for (int unsigned k = 0; k < GRP; k++) begin
        if (j*GRP + k < W) begin
          grp_g[j] = gen[j*GRP + k] | (prop[j*GRP + k] & grp_g[j]);
          grp_p[j] = grp_p[j] & prop[j*GRP + k];
        end
      end
    end

    grp_c    = '0;
    grp_c[0] = carry_q;
    for (int unsigned j = 0; j < NG; j++) begin
      grp_c[j+1] = grp_g[j] | (grp_p[j] & grp_c[j]);
    end

    c = '0;
    for (int unsigned b = 0; b < W; b++) begin
      if (b % GRP == 0) begin
        c[b] = grp_c[b / GRP];
      end else begin
        c[b] = gen[b-1] | (prop[b-1] & c[b-1]);
      end
    end
    c[W] = grp_c[NG];

    slice_sum = prop ^ c[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      idx         <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_q     <= op_a;
            b_q     <= sub ? ~op_b : op_b;
            carry_q <= sub;
            idx     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          result_q[idx*W +: W] <= slice_sum;
          carry_q              <= c[W];
          idx                  <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            carry_out_q <= c[W];
            overflow_q  <= c[W-1] ^ c[W];
            state       <= DONE;
          end
        end
        DONE: begin
          if (done_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign start_ready = (state == IDLE);
  assign done_valid  = (state == DONE);
  assign result      = result_q;
  assign carry_out   = carry_out_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed bench for multiword_add_sequencer (W=16, K=4) with hand-computed
// expected results; inputs driven and outputs sampled on the falling edge.
module tb_multiword_add_sequencer;

  localparam int unsigned W = 16;
  localparam int unsigned K = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           start_valid;
  logic           start_ready;
  logic [W*K-1:0] op_a;
  logic [W*K-1:0] op_b;
  logic           sub;
  logic [W*K-1:0] result;
  logic           carry_out;
  logic           overflow;
  logic           done_valid;
  logic           done_ready;

  int vectors     = 0;
  int miscompares = 0;

  multiword_add_sequencer #(.W(W), .K(K)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .sub         (sub),
    .result      (result),
    .carry_out   (carry_out),
    .overflow    (overflow),
    .done_valid  (done_valid),
    .done_ready  (done_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one request, checks done_valid timing, the result and the return to IDLE.
  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic s, input logic [63:0] exp_r,
                        input logic exp_c, input logic exp_o);
    chk({tag, ".start_ready"}, 64'(start_ready), 64'd1);
    start_valid = 1'b1;
    op_a        = a;
    op_b        = b;
    sub         = s;
    @(negedge clk);
    start_valid = 1'b0;
    op_a        = '0;
    op_b        = '0;
    sub         = 1'b0;
    chk({tag, ".busy"}, 64'(start_ready), 64'd0);
    for (int i = 1; i <= int'(K); i++) begin
      @(negedge clk);
      if (i < int'(K)) chk({tag, ".early_done"}, 64'(done_valid), 64'd0);
      else             chk({tag, ".done_at_K"},  64'(done_valid), 64'd1);
    end
    chk({tag, ".result"},    result,            exp_r);
    chk({tag, ".carry_out"}, 64'(carry_out),    64'(exp_c));
    chk({tag, ".overflow"},  64'(overflow),     64'(exp_o));
    done_ready = 1'b1;
    @(negedge clk);
    done_ready = 1'b0;
    chk({tag, ".idle_ready"}, 64'(start_ready), 64'd1);
    chk({tag, ".idle_done"},  64'(done_valid),  64'd0);
  endtask

  initial begin
    rst         = 1'b1;
    start_valid = 1'b0;
    op_a        = '0;
    op_b        = '0;
    sub         = 1'b0;
    done_ready  = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset.start_ready", 64'(start_ready), 64'd1);
    chk("reset.done_valid",  64'(done_valid),  64'd0);
    chk("reset.result",      result,           64'd0);
    chk("reset.carry_out",   64'(carry_out),   64'd0);
    chk("reset.overflow",    64'(overflow),    64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("ripple", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0,
           64'h0000_0000_0001_0000, 1'b0, 1'b0);
    run_op("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
           64'h0, 1'b1, 1'b0);
    run_op("sub_ovf", 64'h8000_0000_0000_0000, 64'h1, 1'b1,
           64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    run_op("borrow", 64'h0, 64'h1, 1'b1,
           64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    run_op("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
           64'h8000_0000_0000_0000, 1'b0, 1'b1);
    run_op("sub_eq", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1,
           64'h0, 1'b1, 1'b0);

    // Backpressure: hold DONE with done_ready low while new requests knock.
    start_valid = 1'b1;
    op_a        = 64'h1234_5678_9ABC_DEF0;
    op_b        = 64'h1111_1111_1111_1111;
    sub         = 1'b0;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (K) @(negedge clk);
    chk("bp.done_valid", 64'(done_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      start_valid = (i % 2 == 0);
      op_a        = 64'hDEAD_BEEF_0000_0001;
      op_b        = 64'h0000_0000_0000_0007;
      sub         = 1'b1;
      @(negedge clk);
      chk("bp.hold_done",   64'(done_valid),  64'd1);
      chk("bp.hold_ready",  64'(start_ready), 64'd0);
      chk("bp.hold_result", result,           64'h2345_6789_ABCD_F001);
      chk("bp.hold_carry",  64'(carry_out),   64'd0);
      chk("bp.hold_ovf",    64'(overflow),    64'd0);
    end
    start_valid = 1'b0;
    done_ready  = 1'b1;
    @(negedge clk);
    done_ready  = 1'b0;
    chk("bp.release_ready", 64'(start_ready), 64'd1);
    chk("bp.release_done",  64'(done_valid),  64'd0);
    // Nothing was queued: staying idle shows no second operation started.
    repeat (K + 1) @(negedge clk);
    chk("bp.no_queue_ready", 64'(start_ready), 64'd1);
    chk("bp.no_queue_done",  64'(done_valid),  64'd0);

    // Reset mid-RUN at idx == 2.
    start_valid = 1'b1;
    op_a        = 64'hFFFF_FFFF_FFFF_FFFF;
    op_b        = 64'hFFFF_FFFF_FFFF_FFFF;
    sub         = 1'b0;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_run.start_ready", 64'(start_ready), 64'd1);
    chk("rst_run.done_valid",  64'(done_valid),  64'd0);
    chk("rst_run.result",      result,           64'd0);
    chk("rst_run.carry_out",   64'(carry_out),   64'd0);
    run_op("after_rst", 64'h5, 64'h3, 1'b0, 64'h8, 1'b0, 1'b0);

    // Reset together with start_valid: the request must not be taken.
    rst         = 1'b1;
    start_valid = 1'b1;
    op_a        = 64'h5;
    op_b        = 64'h3;
    @(negedge clk);
    rst         = 1'b0;
    start_valid = 1'b0;
    chk("rst_start.ready", 64'(start_ready), 64'd1);
    repeat (K + 1) @(negedge clk);
    chk("rst_start.no_done", 64'(done_valid), 64'd0);

    // done_ready while idle has no effect.
    done_ready = 1'b1;
    @(negedge clk);
    done_ready = 1'b0;
    chk("idle_dr.ready", 64'(start_ready), 64'd1);
    run_op("final", 64'h0001_0000_FFFF_0000, 64'h0000_FFFF_0001_FFFF, 1'b0,
           64'h0002_0000_0000_FFFF, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
